// File: rtl/mult_pkg.sv
// mult_pkg: shared width default, command encoding and counter sizing for the shift-add multiplier.
package mult_pkg;
   localparam int MULT_N = 4;
   typedef enum logic [1:0] {CMD_HOLD, CMD_LOAD, CMD_ADDSHIFT, CMD_SHIFT} cmd_t;
   function automatic int cnt_width(input int n);
      return $clog2(n) + 1;
   endfunction
   function automatic cmd_t decode_cmd(input logic load, input logic add_shift, input logic shift);
      return load ? CMD_LOAD : add_shift ? CMD_ADDSHIFT : shift ? CMD_SHIFT : CMD_HOLD;
   endfunction
endpackage

// File: rtl/mult_step_counter.sv
// mult_step_counter: saturating step counter with clear, enable, terminal-count (tc) and saturation flags.
module mult_step_counter import mult_pkg::*; #(
   parameter int N = MULT_N,
   parameter int W = cnt_width(N)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc,
   output logic sat
);
   logic [W-1:0] cnt;
   assign sat = cnt == W'(N);
   assign tc  = cnt == W'(N - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (en && !sat) cnt <= cnt + 1'b1;
endmodule

// File: rtl/mult_datapath.sv
// mult_datapath: shift-add multiplier datapath (A, Q, B registers plus step counter).
// Define MULT_SIGNED_EN for two's-complement operands with arithmetic shift and honoured Cm.
module mult_datapath import mult_pkg::*; #(
   parameter int N = MULT_N
) (
   input  logic           CLK,
   input  logic           Reset,
   input  logic [N-1:0]   Mcand,
   input  logic [N-1:0]   Mplier,
   input  logic           Load,
   input  logic           AddRshift,
   input  logic           Rshift,
   input  logic           Cm,
   output logic           M,
   output logic           K,
   output logic [2*N-1:0] Product
);
   logic [N:0]   a, s, addend, acc;
   logic [N-1:0] q, b;
   logic         sat, top, shift_en;
   cmd_t         cmd;
   assign cmd = decode_cmd(Load, AddRshift, Rshift);
`ifdef MULT_SIGNED_EN
   assign addend = Cm ? -{b[N-1], b} : {b[N-1], b};
   assign top    = cmd == CMD_ADDSHIFT ? s[N] : a[N];
`else
   logic cm_unused;
   assign cm_unused = Cm;
   assign addend    = {1'b0, b};
   assign top       = 1'b0;
`endif
   assign s        = a + addend;
   assign acc      = cmd == CMD_ADDSHIFT ? s : a;
   assign shift_en = (cmd == CMD_ADDSHIFT || cmd == CMD_SHIFT) && !sat;
   // Once the counter saturates, further shifts are dropped so the product holds.
   always_ff @(posedge CLK or negedge Reset)
      if (!Reset) begin
         a <= '0;
         q <= '0;
         b <= '0;
      end else if (cmd == CMD_LOAD) begin
         a <= '0;
         q <= Mplier;
         b <= Mcand;
      end else if (shift_en) begin
         {a, q} <= {top, acc, q[N-1:1]};
      end
   mult_step_counter #(.N(N)) u_cnt (
      .clk   (CLK),
      .rst_n (Reset),
      .clr   (cmd == CMD_LOAD),
      .en    (shift_en),
      .tc    (K),
      .sat   (sat)
   );
   assign M       = q[0];
   assign Product = {a[N-1:0], q};
endmodule

// File: doc/mult_datapath.md
# mult_datapath

Shift-add multiplier datapath driven by the multiplier controller. It holds the multiplicand, multiplier/partial-product shift register, accumulator and step counter. It executes the controller's Load / AddRshift / Rshift / Cm commands and returns the status bits M (current multiplier LSB) and K (last step) plus the 2N-bit Product.

## Interface
- N, 4: operand width in bits (≥2); Product is 2N bits
- CLK  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset; clears all state
- Mcand  in  N  multiplicand, sampled on Load
- Mplier  in  N  multiplier, sampled on Load
- Load  in  1  initialise registers from operands
- AddRshift  in  1  add (or subtract, see Cm) multiplicand into accumulator, then shift right
- Rshift  in  1  shift right without add
- Cm  in  1  with AddRshift: use two's complement of multiplicand (signed correction step)
- M  out  1  Q[0], multiplier bit for the current step
- K  out  1  high while the step counter is at N-1, i.e. during the cycle the final shift is commanded
- Product  out  2N  {A[N-1:0], Q}

## Operation
- Registers: A (N+1 bits, accumulator plus carry/sign), Q (N bits), B (N bits), cnt (clog2(N)+1 bits).
- Command priority per cycle: Load > AddRshift > Rshift > hold. Multiple commands asserted: highest wins, others ignored.
- Load: A←0, Q←Mplier, B←Mcand, cnt←0.
- AddRshift: S = A + ext(Cm ? −B : B), computed at N+1 bits; {A,Q} ← {top, S, Q} >> 1; cnt←cnt+1.
- Rshift: {A,Q} ← {top, A, Q} >> 1; cnt←cnt+1.
- top bit: unsigned mode, 0 (A[N] carries the add carry into A[N-1] on shift); signed mode, S[N] / A[N] (arithmetic shift).
- Cm without AddRshift has no effect.
- Counter saturates at N. Shift commands with cnt==N are ignored: A, Q, cnt hold. K therefore pulses exactly once per operation.
- M = Q[0] and K = (cnt==N-1) are combinational from registers; Product is combinational from A, Q.

## Timing
- Reset (async, Reset=0): A, Q, B, cnt = 0, so M=0, K=0, Product=0 immediately, independent of CLK.
- Reset mid-operation: state cleared; the next Load is required before shifts take effect meaningfully.
- Load at edge t: M valid (Mplier[0]) after t.
- One shift per cycle; N shift cycles after Load. K is high during the Nth shift cycle. Product final after the edge ending that cycle.
- Total latency Load→Product valid: N+1 edges.
- Load during shifting restarts cleanly on that edge; cnt←0, K drops.
- Product stays stable until the next Load or Reset.

## Configuration
- MULT_SIGNED_EN defined: two's-complement operands. A is sign-extended on shift, and Cm is honoured; the controller asserts Cm on the final step when M=1.
- MULT_SIGNED_EN undefined: unsigned operands. Logical shift with carry-in from the add, and the Cm input is ignored (treated as 0).

## Structure
- Shared package mult_pkg: default width constant MULT_N, command priority enum (CMD_HOLD, CMD_LOAD, CMD_ADDSHIFT, CMD_SHIFT), counter width function.
- Sub-module mult_step_counter: saturating counter with clear, enable and terminal-count (K) output. The rest stays in mult_datapath.

## Test plan
- Reset asserted asynchronously between edges -> Product=0, M=0, K=0 before the next CLK edge.
- Unsigned N=4, Mcand=15, Mplier=15, controller-style sequence Load then 4 steps (AddRshift when M=1) -> Product=8'hE1 (225), K high only on the 4th step.
- Unsigned 9×0 -> only Rshift steps, Product=8'h00. Extra Rshift after the 4th step -> Product and K unchanged.
- MULT_SIGNED_EN, Mcand=4'b1101 (−3), Mplier=4'b0101 (5) -> Product=8'hF1 (−15).
- MULT_SIGNED_EN, Mcand=5, Mplier=−3, Cm with the final AddRshift -> Product=8'hF1. Same run without Cm on the final step -> 8'h41, confirming Cm is required.
- Load asserted together with AddRshift mid-operation (cnt=2) -> Load wins, cnt=0, Q=new Mplier. A subsequent full run gives the correct product.
